// File: rtl/gene_pkg.sv
// Shared types and constants for the alignment traceback path:
// op codes, matrix ids, direction-nibble encoding and memory geometry.
package gene_pkg;

  localparam int BANK_W = 4;
  localparam int ADDR_W = 9;
  localparam int WORD_W = 64;
  localparam int NIB_W  = 4;

  typedef enum logic [1:0] {
    OP_M = 2'd0,
    OP_I = 2'd1,
    OP_D = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    MAT_V = 2'd0,
    MAT_I = 2'd1,
    MAT_D = 2'd2
  } mat_e;

  localparam logic [1:0] VC_STOP   = 2'd0;
  localparam logic [1:0] VC_DIAG   = 2'd1;
  localparam logic [1:0] VC_TAKE_I = 2'd2;
  localparam logic [1:0] VC_TAKE_D = 2'd3;

  localparam int I_EXT_BIT = 2;
  localparam int D_EXT_BIT = 3;

  function automatic logic [NIB_W-1:0] get_nib(input logic [WORD_W-1:0] word,
                                               input logic [3:0]        idx);
    return word[{idx, 2'b00} +: NIB_W];
  endfunction

endpackage

// File: rtl/tb_addr_map.sv
// Maps a matrix cell to its direction-memory bank/address and pulls the
// cell's nibble out of each of the three 64-bit direction words.
module tb_addr_map
  import gene_pkg::*;
#(
  parameter int ROW_W = 8,
  parameter int COL_W = 9
) (
  input  logic [ROW_W-1:0]  i_row,
  input  logic [COL_W-1:0]  i_col,
  input  logic [WORD_W-1:0] i_word_v,
  input  logic [WORD_W-1:0] i_word_i,
  input  logic [WORD_W-1:0] i_word_d,
  output logic [BANK_W-1:0] o_bank,
  output logic [ADDR_W-1:0] o_addr,
  output logic [3:0]        o_nib_idx,
  output logic [NIB_W-1:0]  o_nib_v,
  output logic [NIB_W-1:0]  o_nib_i,
  output logic [NIB_W-1:0]  o_nib_d
);

  // Rows interleave across banks; each word packs 16 adjacent columns.
  assign o_bank    = i_row[3:0];
  assign o_addr    = {i_row[ROW_W-1:4], i_col[COL_W-1:4]};
  assign o_nib_idx = i_col[3:0];
  assign o_nib_v   = get_nib(i_word_v, i_col[3:0]);
  assign o_nib_i   = get_nib(i_word_i, i_col[3:0]);
  assign o_nib_d   = get_nib(i_word_d, i_col[3:0]);

endmodule

// File: rtl/traceback_ctrl.sv
// Walks stored direction nibbles from an end cell back to the alignment
// start, emitting one M/I/D op per step on a valid/ready stream.
module traceback_ctrl
  import gene_pkg::*;
#(
  parameter int ROW_W = 8,
  parameter int COL_W = 9,
  parameter int LEN_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ROW_W-1:0]  i_row,
  input  logic [COL_W-1:0]  i_col,
  input  logic [1:0]        i_mat,
  output logic              o_mem_wen,
  output logic [BANK_W-1:0] o_mem_bank,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [WORD_W-1:0] i_dir_v,
  input  logic [WORD_W-1:0] i_dir_i,
  input  logic [WORD_W-1:0] i_dir_d,
  output logic              o_op_valid,
  output logic [1:0]        o_op,
  input  logic              i_op_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_edge,
  output logic [ROW_W-1:0]  o_end_row,
  output logic [COL_W-1:0]  o_end_col,
  output logic [LEN_W-1:0]  o_len
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECIDE = 3'd2,
    ST_EMIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d, nrow_q, nrow_d, end_row_q, end_row_d;
  logic [COL_W-1:0]   col_q, col_d, ncol_q, ncol_d, end_col_q, end_col_d;
  mat_e               mat_q, mat_d, nmat_q, nmat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  op_e                op_q, op_d;
  logic               op_valid_q, op_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               edge_q, edge_d;
  logic               term_edge_q, term_edge_d;

  logic [3:0]         nib_idx_s;
  logic [NIB_W-1:0]   nib_v_s, nib_i_s, nib_d_s;
  logic               stop_s, step_edge_s;
  op_e                step_op_s;
  mat_e               step_mat_s;
  logic [ROW_W-1:0]   step_row_s;
  logic [COL_W-1:0]   step_col_s;

  tb_addr_map #(.ROW_W(ROW_W), .COL_W(COL_W)) u_map (
    .i_row     (row_q),
    .i_col     (col_q),
    .i_word_v  (i_dir_v),
    .i_word_i  (i_dir_i),
    .i_word_d  (i_dir_d),
    .o_bank    (o_mem_bank),
    .o_addr    (o_mem_addr),
    .o_nib_idx (nib_idx_s),
    .o_nib_v   (nib_v_s),
    .o_nib_i   (nib_i_s),
    .o_nib_d   (nib_d_s)
  );

  // Resolve one traceback step; V take-I/D codes fold into the I/D move at the same cell.
  always_comb begin
    stop_s      = 1'b0;
    step_op_s   = OP_M;
    step_mat_s  = MAT_V;
    step_row_s  = row_q;
    step_col_s  = col_q;
    step_edge_s = 1'b0;
    if (mat_q == MAT_I) begin
      step_op_s = OP_I;
    end else if (mat_q == MAT_D) begin
      step_op_s = OP_D;
    end else begin
      case (nib_v_s[1:0])
        VC_STOP:   stop_s    = 1'b1;
        VC_DIAG:   step_op_s = OP_M;
        VC_TAKE_I: step_op_s = OP_I;
        VC_TAKE_D: step_op_s = OP_D;
        default:   stop_s    = 1'b1;
      endcase
    end
    case (step_op_s)
      OP_M: begin
        step_row_s  = (row_q == '0) ? row_q : row_q - ROW_W'(1);
        step_col_s  = (col_q == '0) ? col_q : col_q - COL_W'(1);
        step_edge_s = (row_q == '0) || (col_q == '0);
        step_mat_s  = MAT_V;
      end
      OP_I: begin
        step_row_s  = (row_q == '0) ? row_q : row_q - ROW_W'(1);
        step_edge_s = (row_q == '0);
        step_mat_s  = nib_i_s[I_EXT_BIT] ? MAT_I : MAT_V;
      end
      OP_D: begin
        step_col_s  = (col_q == '0) ? col_q : col_q - COL_W'(1);
        step_edge_s = (col_q == '0);
        step_mat_s  = nib_d_s[D_EXT_BIT] ? MAT_D : MAT_V;
      end
      default: begin
        stop_s = 1'b1;
      end
    endcase
  end

  // Next-state and registered-output logic of the walk FSM.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    mat_d       = mat_q;
    nrow_d      = nrow_q;
    ncol_d      = ncol_q;
    nmat_d      = nmat_q;
    term_edge_d = term_edge_q;
    len_d       = len_q;
    op_d        = op_q;
    op_valid_d  = op_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    edge_d      = edge_q;
    end_row_d   = end_row_q;
    end_col_d   = end_col_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          row_d   = i_row;
          col_d   = i_col;
          mat_d   = (i_mat == 2'd3) ? MAT_V : mat_e'(i_mat);
          len_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_d = ST_DECIDE;
      end
      ST_DECIDE: begin
        if (stop_s) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          edge_d    = 1'b0;
          end_row_d = row_q;
          end_col_d = col_q;
        end else begin
          op_d        = step_op_s;
          op_valid_d  = 1'b1;
          nrow_d      = step_row_s;
          ncol_d      = step_col_s;
          nmat_d      = step_mat_s;
          term_edge_d = step_edge_s;
          state_d     = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (i_op_ready) begin
          op_valid_d = 1'b0;
          len_d      = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + LEN_W'(1);
          row_d      = nrow_q;
          col_d      = ncol_q;
          mat_d      = nmat_q;
          if (term_edge_q) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            edge_d    = 1'b1;
            end_row_d = nrow_q;
            end_col_d = ncol_q;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        op_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      mat_q       <= MAT_V;
      nrow_q      <= '0;
      ncol_q      <= '0;
      nmat_q      <= MAT_V;
      term_edge_q <= 1'b0;
      len_q       <= '0;
      op_q        <= OP_M;
      op_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      edge_q      <= 1'b0;
      end_row_q   <= '0;
      end_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      mat_q       <= mat_d;
      nrow_q      <= nrow_d;
      ncol_q      <= ncol_d;
      nmat_q      <= nmat_d;
      term_edge_q <= term_edge_d;
      len_q       <= len_d;
      op_q        <= op_d;
      op_valid_q  <= op_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      edge_q      <= edge_d;
      end_row_q   <= end_row_d;
      end_col_q   <= end_col_d;
    end
  end

  assign o_mem_wen  = 1'b1;
  assign o_op_valid = op_valid_q;
  assign o_op       = op_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_edge     = edge_q;
  assign o_end_row  = end_row_q;
  assign o_end_col  = end_col_q;
  assign o_len      = len_q;

endmodule

// File: tb/tb_traceback_ctrl.sv
// Directed bench for traceback_ctrl with a behavioural banked direction memory.
module tb_traceback_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  row = '0;
  logic [8:0]  col = '0;
  logic [1:0]  mat = '0;
  logic        ready = 1'b1;
  logic        mem_wen, op_valid, busy, done, edge_o;
  logic [3:0]  mem_bank;
  logic [8:0]  mem_addr;
  logic [1:0]  op;
  logic [7:0]  end_row;
  logic [8:0]  end_col;
  logic [9:0]  len;
  logic [63:0] rd_v = '0, rd_i = '0, rd_d = '0;
  logic [63:0] mem_v [0:8191];
  logic [63:0] mem_i [0:8191];
  logic [63:0] mem_d [0:8191];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int op_cyc = 0;
  int prev_cyc = 0;
  logic saw_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    rd_v <= mem_v[{mem_bank, mem_addr}];
    rd_i <= mem_i[{mem_bank, mem_addr}];
    rd_d <= mem_d[{mem_bank, mem_addr}];
  end

  traceback_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_row(row), .i_col(col), .i_mat(mat),
    .o_mem_wen(mem_wen), .o_mem_bank(mem_bank), .o_mem_addr(mem_addr),
    .i_dir_v(rd_v), .i_dir_i(rd_i), .i_dir_d(rd_d),
    .o_op_valid(op_valid), .o_op(op), .i_op_ready(ready), .o_busy(busy), .o_done(done),
    .o_edge(edge_o), .o_end_row(end_row), .o_end_col(end_col), .o_len(len)
  );

  function automatic int cell_word(input int r, input int c);
    return (r % 16) * 512 + (r / 16) * 32 + (c / 16);
  endfunction

  task automatic set_nib(input int m, input int r, input int c, input logic [3:0] n);
    int a;
    int s;
    a = cell_word(r, c);
    s = (c % 16) * 4;
    if (m == 0) mem_v[a][s +: 4] = n;
    else if (m == 1) mem_i[a][s +: 4] = n;
    else mem_d[a][s +: 4] = n;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int r, input int c, input int m);
    row = 8'(r);
    col = 9'(c);
    mat = 2'(m);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for a valid op, checks it, and takes the handshake if ready is high.
  task automatic expect_op(input string tag, input logic [1:0] exp);
    int k;
    k = 0;
    while (!op_valid && k < 20) begin
      tick();
      k++;
    end
    check({tag, " valid"}, 32'(op_valid), 32'd1);
    check({tag, " op"}, 32'(op), 32'(exp));
    prev_cyc = op_cyc;
    op_cyc = cyc;
    if (ready) tick();
  endtask

  task automatic expect_done(input string tag, input int r, input int c, input int l, input logic e);
    int k;
    k = 0;
    while (!done && k < 20) begin
      tick();
      k++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " end_row"}, 32'(end_row), 32'(r));
    check({tag, " end_col"}, 32'(end_col), 32'(c));
    check({tag, " len"}, 32'(len), 32'(l));
    check({tag, " edge"}, 32'(edge_o), 32'(e));
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) begin
      mem_v[a] = '0;
      mem_i[a] = '0;
      mem_d[a] = '0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst valid", 32'(op_valid), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst edge", 32'(edge_o), 32'd0);
    check("rst op", 32'(op), 32'd0);
    check("rst end_row", 32'(end_row), 32'd0);
    check("rst end_col", 32'(end_col), 32'd0);
    check("rst len", 32'(len), 32'd0);
    check("rst wen", 32'(mem_wen), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Pure diagonal from (5,5) stopping at (2,2).
    set_nib(0, 5, 5, 4'h1);
    set_nib(0, 4, 4, 4'h1);
    set_nib(0, 3, 3, 4'h1);
    set_nib(0, 2, 2, 4'h0);
    do_start(5, 5, 0);
    check("diag busy", 32'(busy), 32'd1);
    check("diag bank", 32'(mem_bank), 32'd5);
    check("diag addr", 32'(mem_addr), 32'd0);
    expect_op("diag op1", 2'd0);
    expect_op("diag op2", 2'd0);
    check("diag throughput", 32'(op_cyc - prev_cyc), 32'd3);
    expect_op("diag op3", 2'd0);
    expect_done("diag", 2, 2, 3, 1'b0);
    // A start coincident with DONE must be ignored.
    do_start(9, 9, 0);
    check("start in done ignored", 32'(busy), 32'd0);
    tick();
    check("idle after done", 32'(busy), 32'd0);
    check("len held", 32'(len), 32'd3);
    check("end_row held", 32'(end_row), 32'd2);

    // Affine insertion run from (10,3).
    set_nib(0, 10, 3, 4'h2);
    set_nib(1, 10, 3, 4'h4);
    set_nib(1, 9, 3, 4'h4);
    set_nib(1, 8, 3, 4'h0);
    set_nib(0, 7, 3, 4'h0);
    do_start(10, 3, 0);
    expect_op("ins op1", 2'd1);
    expect_op("ins op2", 2'd1);
    expect_op("ins op3", 2'd1);
    expect_done("ins", 7, 3, 3, 1'b0);
    tick();

    // Deletions running into column 0.
    set_nib(0, 0, 4, 4'h3);
    for (int c = 0; c <= 4; c++) set_nib(2, 0, c, 4'h8);
    do_start(0, 4, 0);
    for (int s = 0; s < 5; s++) expect_op("bnd op", 2'd2);
    expect_done("bnd", 0, 0, 5, 1'b1);
    tick();

    // Backpressure, with i_mat=3 acting as V and a start while busy.
    set_nib(0, 20, 30, 4'h1);
    set_nib(0, 19, 29, 4'h1);
    set_nib(0, 18, 28, 4'h0);
    ready = 1'b0;
    do_start(20, 30, 3);
    expect_op("bp op1", 2'd0);
    for (int s = 0; s < 4; s++) begin
      check("bp valid held", 32'(op_valid), 32'd1);
      check("bp op held", 32'(op), 32'd0);
      check("bp len held", 32'(len), 32'd0);
      check("bp bank held", 32'(mem_bank), 32'd4);
      check("bp addr held", 32'(mem_addr), 32'd33);
      if (s == 1) begin
        row = 8'd100;
        col = 9'd100;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    ready = 1'b1;
    tick();
    check("bp len after", 32'(len), 32'd1);
    expect_op("bp op2", 2'd0);
    expect_done("bp", 18, 28, 2, 1'b0);
    tick();

    // Addressing of (0x37, 0x1A5): only nibble 5 of the word holds a stop.
    mem_v[cell_word(8'h37, 9'h1A5)] = 64'h1111_1111_1111_1111;
    set_nib(0, 8'h37, 9'h1A5, 4'h0);
    do_start(8'h37, 9'h1A5, 0);
    check("addr bank", 32'(mem_bank), 32'd7);
    check("addr addr", 32'(mem_addr), 32'h07A);
    expect_done("addr", 8'h37, 9'h1A5, 0, 1'b0);
    tick();

    // Reset during EMIT aborts the walk silently.
    ready = 1'b0;
    do_start(5, 5, 0);
    expect_op("rstw op1", 2'd0);
    rst_n = 1'b0;
    #1;
    check("rstw valid", 32'(op_valid), 32'd0);
    check("rstw busy", 32'(busy), 32'd0);
    check("rstw end_row", 32'(end_row), 32'd0);
    check("rstw end_col", 32'(end_col), 32'd0);
    check("rstw len", 32'(len), 32'd0);
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("rstw no done", 32'(saw_done), 32'd0);
    check("rstw idle", 32'(busy), 32'd0);

    do_start(5, 5, 0);
    for (int s = 0; s < 3; s++) expect_op("rerun op", 2'd0);
    expect_done("rerun", 2, 2, 3, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
